mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4:1 select mux (address1:address0, in0..in3) between
//  four requesters. It grants one requester at a time and drives the mux address lines.
//  It waits a settle interval for gate delay after each address change before raising sel_valid.
//  It bounds hold time by preempting a requester that holds the mux too long while others wait.
// PARAMETERS
//  SETTLE_CYCLES  1   clock cycles from address change to sel_valid high (0..15)
//  MAX_HOLD       16  max cycles in GRANT before preemption if others wait (0 = never preempt)
//  CNT_W          5   width of settle/hold counters (must hold max(SETTLE_CYCLES, MAX_HOLD))
// PORTS
//  clk        in   1  single clock; all state updates on the rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  req        in   4  req[i]=1: requester i wants the mux; held high for the whole use
//  gnt        out  4  one-hot grant (or 0); registered
//  address0   out  1  mux select LSB = grant index bit 0; registered
//  address1   out  1  mux select MSB = grant index bit 1; registered
//  sel_valid  out  1  1 = address stable and settled; mux out is valid for gnt owner
//  timeout    out  1  one-cycle pulse when the current owner is preempted
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, gnt=0, address1:0=00, sel_valid=0, timeout=0,
//   last-owner pointer=3 (priority starts at 0), counters=0. Applies immediately,
//   including mid-grant. First edge after deassertion behaves as IDLE.
//  Arbitration: winner = first i with req[i]=1, scanning last+1, last+2, ... mod 4;
//   the current owner is excluded on handoff. Selecting a winner in cycle N sets gnt,
//   address1:0 and last at edge N+1.
//  States:
//   IDLE   : gnt=0, sel_valid=0; address holds its previous value. If any req: grant winner
//            -> SETTLE (-> GRANT directly if SETTLE_CYCLES=0); else stay.
//   SETTLE : gnt/address held, sel_valid=0, settle counter increments each cycle.
//            After SETTLE_CYCLES cycles in SETTLE -> GRANT, so sel_valid rises exactly
//            SETTLE_CYCLES edges after gnt.
//            If req[owner] drops -> release (see below).
//   GRANT  : sel_valid=1; hold counter increments and saturates at MAX_HOLD.
//            If req[owner] drops -> release.
//  Release (owner req low at an edge): if another req is pending, hand off to the next
//   winner on that same edge -> SETTLE (gnt changes directly, no idle bubble). Otherwise
//   gnt=0, sel_valid=0 -> IDLE. Counters clear on every new grant.
//  Preemption: MAX_HOLD!=0, in GRANT, hold counter == MAX_HOLD, and another req pending
//   -> at the next edge hand off as on release, with timeout=1 for that one cycle.
//   If no other req is pending, the owner keeps the grant (no timeout).
//   The preempted requester may re-request; it is lowest priority at that point.
//  Invariants: gnt is one-hot or zero. {address1,address0} == index(gnt) whenever gnt!=0.
//   sel_valid=1 implies gnt!=0 and state GRANT. sel_valid is 0 on the first cycle
//   of any new grant (settle), even when SETTLE_CYCLES=0.
//  Simultaneous: release plus a new req on the same edge is resolved by one arbitration
//   with the new req included. req changes on non-owners never disturb the current grant.
// TESTING
//  1 Reset, req=0001 from cycle 0, SETTLE=1 -> gnt=0001,addr=00 at edge1; sel_valid=1 at edge2.
//  2 req=1111 held, each owner drops req 3 cycles after sel_valid
//    -> grant order 0,1,2,3,0; no idle cycle between grants.
//  3 MAX_HOLD=4: req0 held forever, req2 raised -> after 4 GRANT cycles timeout=1 pulse,
//    gnt=0100,addr=10.
//  4 MAX_HOLD=4, only req1 held 20 cycles -> gnt stays 0010, timeout never asserts.
//  5 Owner drops req during SETTLE with none pending -> gnt=0, sel_valid never rose, IDLE.
//  6 rst_n low mid-GRANT (asynchronous to clk) -> gnt=0, sel_valid=0, addr=00 immediately;
//    after release req=1000 -> granted index 3.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 select mux between four requesters.
// Inserts a settle interval after each address change and preempts long holders.
module mux_rr_arbiter #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned MAX_HOLD      = 16,
   parameter int unsigned CNT_W         = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       address0,
   output logic       address1,
   output logic       sel_valid,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, GRANT = 2'd2} state_t;

   localparam logic [CNT_W:0]   SETTLE_LIM = (CNT_W+1)'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(MAX_HOLD);

   state_t           state, state_nxt;
   logic [1:0]       last, last_nxt;
   logic [CNT_W-1:0] settle_cnt, settle_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_nxt;
   logic [3:0]       gnt_nxt;
   logic [1:0]       addr_nxt;
   logic             sel_valid_nxt, timeout_nxt;
   logic             take, preempt;
   logic [1:0]       take_idx;
   logic [2:0]       any_w, other_w;

   // Returns {found, index}: first requester scanning from+1, from+2, ... (mod 4).
   function automatic logic [2:0] scan(input logic [3:0] r, input logic [1:0] from,
                                       input logic skip_from);
      logic [2:0] res;
      logic [1:0] idx;
      res = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = from + 2'(k);
         if (!res[2] && r[idx] && !(skip_from && idx == from))
            res = {1'b1, idx};
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last       <= 2'd3;
         settle_cnt <= '0;
         hold_cnt   <= '0;
         gnt        <= '0;
         address1   <= 1'b0;
         address0   <= 1'b0;
         sel_valid  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state                <= state_nxt;
         last                 <= last_nxt;
         settle_cnt           <= settle_nxt;
         hold_cnt             <= hold_nxt;
         gnt                  <= gnt_nxt;
         {address1, address0} <= addr_nxt;
         sel_valid            <= sel_valid_nxt;
         timeout              <= timeout_nxt;
      end
   end

   // Release takes precedence over preemption; both hand off without an idle bubble.
   always_comb begin
      any_w     = scan(req, last, 1'b0);
      other_w   = scan(req, last, 1'b1);
      state_nxt = state;
      take      = 1'b0;
      take_idx  = last;
      preempt   = 1'b0;
      case (state)
         IDLE: begin
            if (any_w[2]) begin
               take     = 1'b1;
               take_idx = any_w[1:0];
            end
         end
         SETTLE, GRANT: begin
            if (!req[last]) begin
               if (other_w[2]) begin
                  take     = 1'b1;
                  take_idx = other_w[1:0];
               end else begin
                  state_nxt = IDLE;
               end
            end else if (state == GRANT && MAX_HOLD != 0 && hold_cnt == HOLD_LIM
                         && other_w[2]) begin
               take     = 1'b1;
               take_idx = other_w[1:0];
               preempt  = 1'b1;
            end else if (state == SETTLE &&
                         ({1'b0, settle_cnt} + {{CNT_W{1'b0}}, 1'b1}) >= SETTLE_LIM) begin
               state_nxt = GRANT;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (take)
         state_nxt = (SETTLE_CYCLES == 0) ? GRANT : SETTLE;
   end

   // Hold counter counts GRANT cycles including the current one, saturating at MAX_HOLD.
   always_comb begin
      gnt_nxt       = gnt;
      addr_nxt      = {address1, address0};
      last_nxt      = last;
      settle_nxt    = '0;
      hold_nxt      = '0;
      sel_valid_nxt = (state_nxt == GRANT) && !take;
      timeout_nxt   = preempt;
      if (take) begin
         gnt_nxt  = 4'b0001 << take_idx;
         addr_nxt = take_idx;
         last_nxt = take_idx;
      end else if (state_nxt == IDLE) begin
         gnt_nxt = '0;
      end
      if (state_nxt == SETTLE && !take)
         settle_nxt = settle_cnt + CNT_W'(1);
      if (state_nxt == GRANT) begin
         hold_nxt = take ? '0 : hold_cnt;
         if (hold_nxt < HOLD_LIM)
            hold_nxt = hold_nxt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter against a cycle-level behavioural model.
module tb_mux_rr_arbiter;

   localparam int SET  = 1;
   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       address0, address1, sel_valid, timeout;
   logic [7:0] obs;

   int vectors     = 0;
   int miscompares = 0;

   int m_owner, m_last, m_addr, m_age, m_held;
   bit m_valid, m_to;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.SETTLE_CYCLES(SET), .MAX_HOLD(MAXH), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
      .address0(address0), .address1(address1),
      .sel_valid(sel_valid), .timeout(timeout)
   );

   assign obs = {gnt, address1, address0, sel_valid, timeout};

   task automatic model_reset();
      m_owner = -1; m_last = 3; m_addr = 0; m_age = 0; m_held = 0;
      m_valid = 0;  m_to = 0;
   endtask

   function automatic int winner(logic [3:0] r, int excl);
      for (int k = 1; k <= 4; k++) begin
         int idx = (m_last + k) % 4;
         if (r[idx] && idx != excl) return idx;
      end
      return -1;
   endfunction

   task automatic grant_to(int w);
      m_owner = w; m_last = w; m_addr = w; m_age = 0; m_held = 0; m_valid = 0;
   endtask

   task automatic model_edge(logic [3:0] r);
      int w;
      m_to = 0;
      if (m_owner < 0) begin
         w = winner(r, -1);
         if (w >= 0) grant_to(w);
      end else if (!r[m_owner]) begin
         w = winner(r, m_owner);
         if (w >= 0) grant_to(w);
         else begin m_owner = -1; m_valid = 0; end
      end else begin
         w = winner(r, m_owner);
         if (m_valid && MAXH != 0 && m_held == MAXH && w >= 0) begin
            grant_to(w);
            m_to = 1;
         end else if (!m_valid) begin
            m_age++;
            if (m_age >= SET) begin m_valid = 1; m_held = 1; end
         end else if (m_held < MAXH) begin
            m_held++;
         end
      end
   endtask

   function automatic logic [7:0] exp_vec();
      logic [3:0] g;
      g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      return {g, 2'(m_addr), m_valid, m_to};
   endfunction

   task automatic step(logic [3:0] r);
      req = r;
      @(posedge clk);
      if (rst_n) model_edge(r);
      #1;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      req = 4'b0000;
      model_reset();
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      model_reset();
      #8;
      vectors++;
      if (obs !== 8'h00 || obs !== exp_vec()) begin
         miscompares++;
         $display("FAIL reset got %b want %b", obs, exp_vec());
      end
      #2 rst_n = 1'b1;
   endtask

   task automatic test_single();
      step(4'b0001);
      vectors++;
      if (obs !== exp_vec() || gnt !== 4'b0001 || {address1, address0} !== 2'b00 || sel_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_grant got %b want %b", obs, exp_vec());
      end
      step(4'b0001);
      vectors++;
      if (obs !== exp_vec() || sel_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL single_settle got %b want %b", obs, exp_vec());
      end
   endtask

   task automatic test_rotation();
      int order[$];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int vcnt = 0;
      bit started = 0;
      logic [3:0] r;
      logic [3:0] prev = 4'b0000;
      do_reset();
      for (int c = 0; c < 60 && order.size() < 5; c++) begin
         r = 4'b1111;
         if (m_owner >= 0 && vcnt >= 3) r[m_owner] = 1'b0;
         step(r);
         vcnt = m_valid ? vcnt + 1 : 0;
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL rotation c=%0d got %b want %b", c, obs, exp_vec());
         end
         if (gnt !== prev && gnt !== 4'b0000) order.push_back(int'({address1, address0}));
         if (gnt !== 4'b0000) started = 1;
         vectors++;
         if (started && gnt === 4'b0000) begin
            miscompares++;
            $display("FAIL rotation_bubble c=%0d got gnt %b want nonzero", c, gnt);
         end
         prev = gnt;
      end
      vectors++;
      if (order.size() != 5) begin
         miscompares++;
         $display("FAIL rotation_count got %0d want 5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (order[i] != exp_order[i]) begin
               miscompares++;
               $display("FAIL rotation_order i=%0d got %0d want %0d", i, order[i], exp_order[i]);
            end
         end
      end
   endtask

   task automatic test_preempt();
      bit seen = 0;
      do_reset();
      step(4'b0001);
      step(4'b0001);
      for (int c = 0; c < 12; c++) begin
         step(4'b0101);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL preempt c=%0d got %b want %b", c, obs, exp_vec());
         end
         if (timeout === 1'b1 && gnt === 4'b0100 && {address1, address0} === 2'b10) seen = 1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL preempt_pulse got none want timeout with gnt 0100 addr 10");
      end
   endtask

   task automatic test_lone_hold();
      do_reset();
      for (int c = 0; c < 20; c++) begin
         step(4'b0010);
         vectors++;
         if (obs !== exp_vec() || gnt !== 4'b0010 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL lone_hold c=%0d got %b want %b", c, obs, exp_vec());
         end
      end
   endtask

   task automatic test_settle_drop();
      bit rose = 0;
      do_reset();
      step(4'b0100);
      if (sel_valid) rose = 1;
      vectors++;
      if (obs !== exp_vec() || gnt !== 4'b0100) begin
         miscompares++;
         $display("FAIL settle_grant got %b want %b", obs, exp_vec());
      end
      for (int c = 0; c < 3; c++) begin
         step(4'b0000);
         if (sel_valid) rose = 1;
         vectors++;
         if (obs !== exp_vec() || gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL settle_drop c=%0d got %b want %b", c, obs, exp_vec());
         end
      end
      vectors++;
      if (rose) begin
         miscompares++;
         $display("FAIL settle_valid got 1 want 0");
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(4'b0010);
      step(4'b0010);
      step(4'b0010);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (obs !== 8'h00 || obs !== exp_vec()) begin
         miscompares++;
         $display("FAIL async_reset got %b want %b", obs, exp_vec());
      end
      req = 4'b0000;
      #2 rst_n = 1'b1;
      step(4'b1000);
      vectors++;
      if (obs !== exp_vec() || gnt !== 4'b1000 || {address1, address0} !== 2'b11) begin
         miscompares++;
         $display("FAIL async_regrant got %b want %b", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      logic [3:0] cur = 4'b0000;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
         step(cur);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL random c=%0d req=%b got %b want %b", c, cur, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_preempt();
      test_lone_hold();
      test_settle_drop();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
